seq_deser: RTL and testbench

SEQ_DESER -- requirements
Module: seq_deser

---
 rtl/seq_deser.sv | 149 ++++++++++++++
 tb/tb_seq_deser.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/seq_deser.sv
// Serial frame deserializer: start 0, NBITS data bits LSB first, stop 1, one bit per clk.
// Optional even-parity bit between data and stop when SEQ_DESER_PARITY_EN is defined.
module seq_deser #(
  parameter int unsigned NBITS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rxin,
  output logic [NBITS-1:0] dout,
  output logic             dout_valid,
  output logic             frame_err,
  output logic             busy
);

  localparam int unsigned CNT_W = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NBITS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_STOP = 2'd2
`ifdef SEQ_DESER_PARITY_EN
    , S_PAR = 2'd3
`endif
  } state_t;

  state_t           r_state;
  logic             r_armed;
  logic [CNT_W-1:0] r_cnt;
  logic [NBITS-1:0] r_shift;
  logic [NBITS-1:0] r_dout;
  logic             r_dout_valid;
  logic             r_frame_err;
  logic             r_busy;
`ifdef SEQ_DESER_PARITY_EN
  logic             r_par;
  logic             w_par_nxt;
`endif

  state_t           w_state_nxt;
  logic             w_armed_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [NBITS-1:0] w_shift_nxt;
  logic [NBITS-1:0] w_dout_nxt;
  logic             w_valid_nxt;
  logic             w_ferr_nxt;
  logic             w_busy_nxt;
  logic             w_good;

  // Stop bit plus (optionally) parity decide between a data update and an error pulse.
`ifdef SEQ_DESER_PARITY_EN
  assign w_good = rxin && (r_par == (^r_shift));
`else
  assign w_good = rxin;
`endif

  // Next-state and next-register logic.
  always_comb begin
    w_state_nxt = r_state;
    w_armed_nxt = r_armed;
    w_cnt_nxt   = r_cnt;
    w_shift_nxt = r_shift;
    w_dout_nxt  = r_dout;
    w_valid_nxt = 1'b0;
    w_ferr_nxt  = 1'b0;
`ifdef SEQ_DESER_PARITY_EN
    w_par_nxt   = r_par;
`endif
    case (r_state)
      S_IDLE: begin
        if (rxin) begin
          w_armed_nxt = 1'b1;
        end else if (r_armed) begin
          w_armed_nxt = 1'b0;
          w_cnt_nxt   = '0;
          w_state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        w_shift_nxt[r_cnt] = rxin;
        if (r_cnt == CNT_LAST) begin
`ifdef SEQ_DESER_PARITY_EN
          w_state_nxt = S_PAR;
`else
          w_state_nxt = S_STOP;
`endif
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
`ifdef SEQ_DESER_PARITY_EN
      S_PAR: begin
        w_par_nxt   = rxin;
        w_state_nxt = S_STOP;
      end
`endif
      S_STOP: begin
        w_state_nxt = S_IDLE;
        // A high line on the stop bit re-arms start detection.
        w_armed_nxt = rxin;
        if (w_good) begin
          w_dout_nxt  = r_shift;
          w_valid_nxt = 1'b1;
        end else begin
          w_ferr_nxt  = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_armed      <= 1'b0;
      r_cnt        <= '0;
      r_shift      <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      r_busy       <= 1'b0;
`ifdef SEQ_DESER_PARITY_EN
      r_par        <= 1'b0;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_armed      <= w_armed_nxt;
      r_cnt        <= w_cnt_nxt;
      r_shift      <= w_shift_nxt;
      r_dout       <= w_dout_nxt;
      r_dout_valid <= w_valid_nxt;
      r_frame_err  <= w_ferr_nxt;
      r_busy       <= w_busy_nxt;
`ifdef SEQ_DESER_PARITY_EN
      r_par        <= w_par_nxt;
`endif
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign frame_err  = r_frame_err;
  assign busy       = r_busy;

endmodule

// File: tb/tb_seq_deser.sv
// Bench for seq_deser: directed frames plus random frames, checked cycle by cycle
// against a frame-level model of the serial protocol.
module tb_seq_deser;

  localparam int unsigned NB = 8;
`ifdef SEQ_DESER_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          rxin;
  logic [NB-1:0] dout;
  logic          dout_valid;
  logic          frame_err;
  logic          busy;

  int            n_vec = 0;
  int            n_err = 0;
  logic [NB-1:0] m_dout;
  bit            m_armed;

  seq_deser #(.NBITS(NB)) dut (
    .clk        (clk),
    .rst        (rst),
    .rxin       (rxin),
    .dout       (dout),
    .dout_valid (dout_valid),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic got, input logic exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [NB-1:0] got, input logic [NB-1:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one line bit for one clock, then check all outputs after the edge.
  task automatic step(input logic b, input logic e_busy, input logic e_valid, input logic e_ferr);
    rxin = b;
    @(posedge clk);
    #1;
    chk1("busy", busy, e_busy);
    chk1("dout_valid", dout_valid, e_valid);
    chk1("frame_err", frame_err, e_ferr);
    chkw("dout", dout, m_dout);
  endtask

  task automatic idle_high(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      m_armed = 1'b1;
    end
  endtask

  // Only valid while the model is unarmed: low bits must be ignored.
  task automatic idle_low(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset(input logic line, input int n);
    rst  = 1'b1;
    rxin = line;
    repeat (n) @(posedge clk);
    #1;
    rst     = 1'b0;
    m_dout  = '0;
    m_armed = 1'b0;
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_valid", dout_valid, 1'b0);
    chk1("rst_ferr", frame_err, 1'b0);
    chkw("rst_dout", dout, m_dout);
  endtask

  // Full frame from an armed idle line; pulse lands on the cycle after the stop bit.
  task automatic send_frame(input logic [NB-1:0] d, input logic stop, input logic par);
    bit good;
    step(1'b0, 1'b1, 1'b0, 1'b0);
    m_armed = 1'b0;
    for (int i = 0; i < int'(NB); i++) step(d[i], 1'b1, 1'b0, 1'b0);
`ifdef SEQ_DESER_PARITY_EN
    step(par, 1'b1, 1'b0, 1'b0);
`endif
    good = stop && (!PAR_EN || (par == (^d)));
    if (good) begin
      m_dout = d;
      step(1'b1, 1'b0, 1'b1, 1'b0);
    end else begin
      step(stop, 1'b0, 1'b0, 1'b1);
    end
    m_armed = stop;
  endtask

  initial begin
    logic [NB-1:0] d;
    logic          stop;
    logic          par;
    int            gap;

    // Reset with a stuck-low line, then 20 more low cycles: nothing may start.
    do_reset(1'b0, 2);
    idle_low(20);

    // Good frame 0xA5.
    idle_high(2);
    send_frame(8'hA5, 1'b1, ^8'hA5);

    // Bad stop bit on 0x3C: error pulse, dout holds 0xA5, low line stays ignored.
    idle_high(1);
    send_frame(8'h3C, 1'b0, ^8'h3C);
    idle_low(3);

    // Back-to-back frames 0x01 then 0xFF with no idle gap.
    idle_high(1);
    send_frame(8'h01, 1'b1, ^8'h01);
    send_frame(8'hFF, 1'b1, ^8'hFF);

`ifdef SEQ_DESER_PARITY_EN
    // Wrong then correct parity on 0x07.
    idle_high(1);
    send_frame(8'h07, 1'b1, 1'b0);
    idle_high(1);
    send_frame(8'h07, 1'b1, 1'b1);
`endif

    // Reset during the 4th data bit of 0x5A.
    d = 8'h5A;
    idle_high(1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    m_armed = 1'b0;
    for (int i = 0; i < 3; i++) step(d[i], 1'b1, 1'b0, 1'b0);
    do_reset(d[3], 1);
    idle_low(6);
    idle_high(1);
    send_frame(8'h33, 1'b1, ^8'h33);

    // Random frames with random gaps, stop errors and parity errors.
    for (int k = 0; k < 60; k++) begin
      gap = int'($urandom_range(0, 3));
      if (!m_armed && gap == 0) gap = 1;
      if (!m_armed) idle_low(int'($urandom_range(0, 2)));
      idle_high(gap);
      d    = NB'($urandom);
      stop = ($urandom_range(0, 4) != 0);
      par  = (^d) ^ ($urandom_range(0, 3) == 0);
      send_frame(d, stop, par);
    end
    idle_high(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
